// File: rtl/mmio_timer_peripheral.sv
// rtl/mmio_timer_peripheral.sv - memory-mapped reload timer, LED/digit registers and systick
module mmio_timer_peripheral #(
  parameter logic [31:0] BASE_ADDR    = 32'h40000000,
  parameter int          LED_WIDTH    = 8,
  parameter int          DIGI_WIDTH   = 12,
  parameter logic [31:0] SYSTICK_INIT = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           Address,
  input  logic [31:0]           Write_data,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  output logic [31:0]           Read_data,
  output logic                  Hit,
  output logic                  Irq,
  output logic [LED_WIDTH-1:0]  Leds,
  output logic [DIGI_WIDTH-1:0] Digi
);

  localparam logic [2:0] OFF_TH      = 3'd0;
  localparam logic [2:0] OFF_TL      = 3'd1;
  localparam logic [2:0] OFF_TCON    = 3'd2;
  localparam logic [2:0] OFF_LED     = 3'd3;
  localparam logic [2:0] OFF_DIGI    = 3'd4;
  localparam logic [2:0] OFF_SYSTICK = 3'd5;

  logic [31:0]           th;
  logic [31:0]           tl;
  logic [2:0]            tcon;
  logic [LED_WIDTH-1:0]  led_reg;
  logic [DIGI_WIDTH-1:0] digi_reg;
  logic [31:0]           systick;

  logic [2:0]  offset;
  logic        wr_hit;
  logic        wr_th;
  logic        wr_tl;
  logic        wr_tcon;
  logic        wr_led;
  logic        wr_digi;
  logic        overflow;
  logic [31:0] tl_next;
  logic [2:0]  tcon_next;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^Address[1:0];

  assign offset  = Address[4:2];
  assign Hit     = (Address[31:5] == BASE_ADDR[31:5]) && (offset <= OFF_SYSTICK);
  assign wr_hit  = Hit && MemWrite;
  assign wr_th   = wr_hit && (offset == OFF_TH);
  assign wr_tl   = wr_hit && (offset == OFF_TL);
  assign wr_tcon = wr_hit && (offset == OFF_TCON);
  assign wr_led  = wr_hit && (offset == OFF_LED);
  assign wr_digi = wr_hit && (offset == OFF_DIGI);

  // A CPU write to TL pre-empts the counter, so no overflow can be flagged that edge.
  assign overflow = tcon[0] && (tl == 32'hFFFF_FFFF) && !wr_tl;

  always_comb begin
    tl_next = tl;
    if (wr_tl) begin
      tl_next = Write_data;
    end else if (overflow) begin
      tl_next = th;
    end else if (tcon[0]) begin
      tl_next = tl + 32'd1;
    end
  end

  // Hardware setting irq_status wins over a software clear on the same edge.
  always_comb begin
    tcon_next = wr_tcon ? Write_data[2:0] : tcon;
    if (overflow && tcon[1]) begin
      tcon_next[2] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th       <= 32'h0;
      tl       <= 32'h0;
      tcon     <= 3'b000;
      led_reg  <= '0;
      digi_reg <= '0;
      systick  <= SYSTICK_INIT;
    end else begin
      if (wr_th) begin
        th <= Write_data;
      end
      tl   <= tl_next;
      tcon <= tcon_next;
      if (wr_led) begin
        led_reg <= Write_data[LED_WIDTH-1:0];
      end
      if (wr_digi) begin
        digi_reg <= Write_data[DIGI_WIDTH-1:0];
      end
      systick <= systick + 32'd1;
    end
  end

  always_comb begin
    Read_data = 32'h0;
    if (Hit && MemRead) begin
      case (offset)
        OFF_TH:      Read_data = th;
        OFF_TL:      Read_data = tl;
        OFF_TCON:    Read_data = {29'h0, tcon};
        OFF_LED:     Read_data = {{(32-LED_WIDTH){1'b0}}, led_reg};
        OFF_DIGI:    Read_data = {{(32-DIGI_WIDTH){1'b0}}, digi_reg};
        OFF_SYSTICK: Read_data = systick;
        default:     Read_data = 32'h0;
      endcase
    end
  end

  assign Irq  = tcon[1] & tcon[2];
  assign Leds = led_reg;
  assign Digi = digi_reg;

endmodule

// File: tb/tb_mmio_timer_peripheral.sv
// tb/tb_mmio_timer_peripheral.sv - directed self-checking bench for mmio_timer_peripheral
module tb_mmio_timer_peripheral;

  localparam logic [31:0] BASE      = 32'h40000000;
  localparam logic [31:0] A_TH      = BASE + 32'h00;
  localparam logic [31:0] A_TL      = BASE + 32'h04;
  localparam logic [31:0] A_TCON    = BASE + 32'h08;
  localparam logic [31:0] A_LED     = BASE + 32'h0C;
  localparam logic [31:0] A_DIGI    = BASE + 32'h10;
  localparam logic [31:0] A_SYSTICK = BASE + 32'h14;
  localparam logic [31:0] WRAP_INIT = 32'hFFFF_FFFF - 32'd200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Address = 32'h0;
  logic [31:0] Write_data = 32'h0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Read_data;
  logic        Hit;
  logic        Irq;
  logic [7:0]  Leds;
  logic [11:0] Digi;

  logic [31:0] wrap_read_data;
  logic        wrap_hit;
  logic        wrap_irq;
  logic [7:0]  wrap_leds;
  logic [11:0] wrap_digi;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ticks = 32'h0;
  logic [31:0] rdata;

  mmio_timer_peripheral dut (
    .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .Read_data(Read_data), .Hit(Hit),
    .Irq(Irq), .Leds(Leds), .Digi(Digi)
  );

  mmio_timer_peripheral #(.SYSTICK_INIT(WRAP_INIT)) u_wrap (
    .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .Read_data(wrap_read_data), .Hit(wrap_hit),
    .Irq(wrap_irq), .Leds(wrap_leds), .Digi(wrap_digi)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (reset) ticks <= ticks + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    Address    = addr;
    Write_data = data;
    MemWrite   = 1'b1;
    MemRead    = 1'b0;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    Address  = addr;
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    #1;
    data    = Read_data;
    MemRead = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    #1 reset = 1'b0;

    repeat (3) begin
      @(negedge clk);
      Address    = BASE + 32'($urandom_range(0, 5) << 2);
      Write_data = $urandom;
      MemWrite   = 1'($urandom_range(0, 1));
      MemRead    = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    MemWrite = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus_read(BASE + 32'(i * 4), rdata);
      check($sformatf("rst_reg%0d", i), rdata, 32'h0);
    end
    check("rst_irq", {31'h0, Irq}, 32'h0);
    check("rst_leds", {24'h0, Leds}, 32'h0);
    check("rst_digi", {20'h0, Digi}, 32'h0);
    Address = A_TL;
    #1;
    check("rst_hit", {31'h0, Hit}, 32'h1);
    @(negedge clk);
    reset = 1'b1;

    bus_write(A_TH, 32'hFFFF_FFFC);
    bus_write(A_TL, 32'hFFFF_FFFE);
    bus_write(A_TCON, 32'h3);
    bus_read(A_TL, rdata);
    check("tmr_tl_hold", rdata, 32'hFFFF_FFFE);
    tick();
    bus_read(A_TL, rdata);
    check("tmr_tl_ff", rdata, 32'hFFFF_FFFF);
    check("tmr_irq_pre", {31'h0, Irq}, 32'h0);
    tick();
    bus_read(A_TL, rdata);
    check("tmr_reload", rdata, 32'hFFFF_FFFC);
    check("tmr_irq_set", {31'h0, Irq}, 32'h1);
    bus_read(A_TCON, rdata);
    check("tmr_tcon7", rdata, 32'h7);

    bus_write(A_TCON, 32'h3);
    check("clr_irq", {31'h0, Irq}, 32'h0);
    bus_read(A_TL, rdata);
    check("clr_tl", rdata, 32'hFFFF_FFFD);
    tick();
    tick();
    bus_read(A_TL, rdata);
    check("race_tl_ff", rdata, 32'hFFFF_FFFF);

    bus_write(A_TCON, 32'h3);
    bus_read(A_TCON, rdata);
    check("race_tcon", rdata, 32'h7);
    check("race_irq", {31'h0, Irq}, 32'h1);
    bus_read(A_TL, rdata);
    check("race_tcon_tl", rdata, 32'hFFFF_FFFC);

    bus_write(A_TCON, 32'h3);
    check("clr2_irq", {31'h0, Irq}, 32'h0);
    tick();
    tick();
    bus_read(A_TL, rdata);
    check("race2_tl_ff", rdata, 32'hFFFF_FFFF);
    bus_write(A_TL, 32'h10);
    bus_read(A_TL, rdata);
    check("race_tl_wr", rdata, 32'h10);
    bus_read(A_TCON, rdata);
    check("race_tl_tcon", rdata, 32'h3);

    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TH, 32'h55);
    bus_read(A_TL, rdata);
    check("race_th_reload", rdata, 32'hFFFF_FFFC);
    bus_read(A_TH, rdata);
    check("race_th_new", rdata, 32'h55);
    check("race_th_irq", {31'h0, Irq}, 32'h1);
    bus_write(A_TCON, 32'h0);
    check("dis_irq", {31'h0, Irq}, 32'h0);

    bus_write(A_LED, 32'hFFFF_FFA5);
    check("led_out", {24'h0, Leds}, 32'hA5);
    bus_read(A_LED, rdata);
    check("led_rd", rdata, 32'h0000_00A5);
    bus_write(A_DIGI, 32'h0000_0E3F);
    check("digi_out", {20'h0, Digi}, 32'hE3F);
    bus_read(A_DIGI, rdata);
    check("digi_rd", rdata, 32'h0000_0E3F);

    Address = BASE + 32'h18;
    MemRead = 1'b1;
    #1;
    check("dec18_hit", {31'h0, Hit}, 32'h0);
    check("dec18_rd", Read_data, 32'h0);
    Address = 32'h0000_0010;
    #1;
    check("dec10_hit", {31'h0, Hit}, 32'h0);
    check("dec10_rd", Read_data, 32'h0);
    MemRead = 1'b0;
    bus_write(BASE + 32'h18, 32'h1234_5678);
    bus_write(32'h0000_0010, 32'h0000_0111);
    bus_write(32'h0000_000C, 32'h0000_0022);
    check("dec_leds", {24'h0, Leds}, 32'hA5);
    check("dec_digi", {20'h0, Digi}, 32'hE3F);
    bus_read(A_TH, rdata);
    check("dec_th", rdata, 32'h55);

    bus_write(A_SYSTICK, 32'h0000_1234);
    bus_read(A_SYSTICK, rdata);
    check("systick_wr", rdata, ticks);
    tick();
    bus_read(A_SYSTICK, rdata);
    check("systick_inc", rdata, ticks);

    guard = 0;
    while (ticks < 32'd200 && guard < 1000) begin
      tick();
      guard++;
    end
    check("wrap_reach", ticks, 32'd200);
    Address  = A_SYSTICK;
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    #1;
    check("wrap_ff", wrap_read_data, 32'hFFFF_FFFF);
    tick();
    check("wrap_0", wrap_read_data, 32'h0);
    tick();
    check("wrap_1", wrap_read_data, 32'h1);
    MemRead = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_timer_peripheral.md
Name: mmio_timer_peripheral

Overview:
Memory-mapped peripheral block directly downstream of the multi-cycle CPU's shared memory port. It consumes the same Address, Write_data, MemRead and MemWrite the CPU drives to instruction/data memory. It decodes a fixed peripheral window and provides a reload timer with interrupt, an LED register, a 7-segment digit register and a free-running systick counter. The CPU top muxes read data between memory and this block using the hit flag.

Parameters:
BASE_ADDR, 32'h40000000, word-aligned base of the 6-word peripheral window
LED_WIDTH, 8, width of LED output register
DIGI_WIDTH, 12, width of digit-tube register ([11:8] anode enables, [7:0] segments)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
Address  input  32  byte address from CPU memory port; bits [1:0] ignored
Write_data  input  32  store data
MemRead  input  1  read strobe
MemWrite  input  1  write strobe, sampled on rising clk
Read_data  output  32  combinational read data for the addressed register
Hit  output  1  combinational; 1 when Address[31:5] matches BASE_ADDR[31:5] and word offset is 0..5
Irq  output  1  timer interrupt request = TCON[1] & TCON[2]
Leds  output  LED_WIDTH  LED register contents
Digi  output  DIGI_WIDTH  digit-tube register contents

Behaviour:
- Register map (word offset = Address[4:2]):
  - 0 TH: reload value, R/W.
  - 1 TL: count value, R/W.
  - 2 TCON: [0] enable, [1] irq_en, [2] irq_status, [31:3] read 0. R/W.
  - 3 LED, R/W, low LED_WIDTH bits.
  - 4 DIGI, R/W, low DIGI_WIDTH bits.
  - 5 SYSTICK, read-only; writes are ignored.
  - Offsets 6..7 are not hits.
- Reset (reset==0, asynchronous): TH, TL, TCON, LED, DIGI and SYSTICK all go to 0. Outputs follow: Irq=0, Leds=0, Digi=0. Deassertion is released on the next clk edge; no state changes while reset is low.
- Read path:
  - Read_data = addressed register when Hit & MemRead; otherwise 32'h0.
  - Zero latency; the CPU latches the value into its memory data register on the following edge.
- Write path: when Hit & MemWrite, the addressed register takes Write_data on the rising edge. A non-hit write changes nothing.
- SYSTICK: increments by 1 every cycle out of reset; wraps from 32'hFFFFFFFF to 0.
- Timer, evaluated each cycle when TCON[0]==1:
  - If TL==32'hFFFFFFFF: TL<=TH, and if TCON[1]==1 then TCON[2]<=1 (overflow event).
  - Else TL<=TL+1.
  - When TCON[0]==0, TL holds.
- Simultaneous events, same edge:
  - CPU write to TL beats the timer increment/reload; the written value lands and no overflow is flagged that cycle.
  - CPU write to TH together with an overflow: the reload uses the old TH and the new TH is stored.
  - CPU write to TCON together with an overflow: TCON takes Write_data[2:0], except that bit 2 is forced to 1 if the overflow sets it. Hardware set beats a software clear. Software clears status by writing bit2=0 in a cycle without an overflow.
- Irq is combinational from registered TCON bits, so it is glitch-free. It stays high until software clears irq_status or irq_en.
- MemRead and MemWrite both high: the write occurs on the edge, and Read_data shows the pre-write value during that cycle.
- Reset mid-count: the timer and status return to 0 immediately and Irq drops asynchronously.

Test Plan:
- Reset: hold reset=0 for 3 cycles with random strobes -> every register reads 0; Irq=0, Leds=0, Digi=0; Hit still decodes.
- Timer overflow: write TH=32'hFFFFFFFC, TL=32'hFFFFFFFE, TCON=3'b011 -> TL reads FFFFFFFF after 1 cycle, then FFFFFFFC with Irq=1 on the next edge; after 3 more cycles TL=FFFFFFFF; write TCON=3'b011 -> Irq falls.
- Race: arrange an overflow on the same edge as a TCON write of 3'b011 -> TCON reads 3'b111 and Irq stays 1. Same edge with a TL write of 32'h10 -> TL=32'h10 and status is unchanged.
- LED/DIGI: write 0x40000000+0xC with 32'hFFFF_FFA5 -> Leds=8'hA5 and readback is 32'h000000A5. Write DIGI 32'h0000_0E3F -> Digi=12'hE3F.
- Decode: access 0x40000018 and 0x00000010 -> Hit=0, Read_data=0, no register changes. Write SYSTICK -> value is unaffected and keeps incrementing by 1 per cycle.
- Systick wrap: force SYSTICK near its limit by a long run or a bench preload hook -> reads FFFFFFFF, then 0, then 1.
